// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/inc/dec/logic ops and a WIDTH-cycle
// unsigned shift-add multiplier, with a stored carry flag usable as carry-in.
module alu_seq #(
   parameter int WIDTH       = 16,
   parameter bit CARRY_RESET = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_cin,
   input  logic             carry_wr,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry_out,
   output logic             carry_flag
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_INC = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t                 state_r;
   logic [2*WIDTH-1:0]     prod_r;
   logic [WIDTH-1:0]       mcand_r;
   logic [CW-1:0]          cnt_r;
   logic                   carry_wr_r;
   logic                   busy_r;
   logic                   done_r;
   logic [WIDTH-1:0]       result_r;
   logic [WIDTH-1:0]       result_hi_r;
   logic                   carry_out_r;
   logic                   carry_flag_r;

   logic                   cin_s;
   logic [WIDTH:0]         sum_s;
   logic [WIDTH:0]         part_s;
   logic [2*WIDTH-1:0]     prod_next_s;
   logic                   accept_s;

   assign accept_s = start & ~busy_r;

   // Single-cycle datapath for every op except MUL, evaluated on the live inputs at acceptance
   always_comb begin
      cin_s = use_cin & carry_flag_r;
      sum_s = {(WIDTH+1){1'b0}};
      case (op)
         OP_ADD:  sum_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
         OP_SUB:  sum_s = {1'b0, a} - {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
         OP_INC:  sum_s = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
         OP_DEC:  sum_s = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
         OP_AND:  sum_s = {1'b0, a & b};
         OP_OR:   sum_s = {1'b0, a | b};
         OP_XOR:  sum_s = {1'b0, a ^ b};
         default: sum_s = {(WIDTH+1){1'b0}};
      endcase
   end

   // One shift-add step: upper half accumulates the multiplicand, multiplier bits shift out of the lower half
   always_comb begin
      if (prod_r[0]) begin
         part_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
      end else begin
         part_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
      end
      prod_next_s = {part_s, prod_r[WIDTH-1:1]};
   end

   // Control FSM with registered outputs; results and carry flag commit on the edge entering DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         prod_r       <= {(2*WIDTH){1'b0}};
         mcand_r      <= {WIDTH{1'b0}};
         cnt_r        <= {CW{1'b0}};
         carry_wr_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         result_r     <= {WIDTH{1'b0}};
         result_hi_r  <= {WIDTH{1'b0}};
         carry_out_r  <= 1'b0;
         carry_flag_r <= CARRY_RESET;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (accept_s && (op == OP_MUL)) begin
                  state_r    <= ST_MUL;
                  busy_r     <= 1'b1;
                  prod_r     <= {{WIDTH{1'b0}}, a};
                  mcand_r    <= b;
                  cnt_r      <= {CW{1'b0}};
                  carry_wr_r <= carry_wr;
               end else if (accept_s) begin
                  state_r     <= ST_DONE;
                  done_r      <= 1'b1;
                  result_r    <= sum_s[WIDTH-1:0];
                  result_hi_r <= {WIDTH{1'b0}};
                  carry_out_r <= sum_s[WIDTH];
                  if (carry_wr) begin
                     carry_flag_r <= sum_s[WIDTH];
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MUL: begin
               prod_r <= prod_next_s;
               if (cnt_r == CNT_LAST) begin
                  state_r     <= ST_DONE;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  result_r    <= prod_next_s[WIDTH-1:0];
                  result_hi_r <= prod_next_s[2*WIDTH-1:WIDTH];
                  carry_out_r <= prod_next_s[WIDTH];
                  if (carry_wr_r) begin
                     carry_flag_r <= prod_next_s[WIDTH];
                  end
               end else begin
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign result     = result_r;
   assign result_hi  = result_hi_r;
   assign carry_out  = carry_out_r;
   assign carry_flag = carry_flag_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed vectors push expectations,
// a monitor pops and compares on every done pulse, including done latency.
module tb_alu_seq;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          use_cin = 1'b0;
   logic          carry_wr = 1'b0;
   logic          busy, done, carry_out, carry_flag;
   logic [W-1:0]  result, result_hi;

   typedef struct {
      logic [W-1:0] r;
      logic [W-1:0] hi;
      logic         c;
      logic         f;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   alu_seq #(.WIDTH(W), .CARRY_RESET(1'b0)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .use_cin(use_cin), .carry_wr(carry_wr), .busy(busy), .done(done),
      .result(result), .result_hi(result_hi), .carry_out(carry_out),
      .carry_flag(carry_flag)
   );

   always #5 clk = ~clk;

   // Edge counter: at the falling edge after rising edge n, cyc == n
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && done) begin
         if (q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result",       32'(result),    32'(e.r));
            chk("result_hi",    32'(result_hi), 32'(e.hi));
            chk("carry_out",    32'(carry_out), 32'(e.c));
            chk("carry_flag",   32'(carry_flag), 32'(e.f));
            chk("done_latency", 32'(cyc),       32'(e.cyc));
            chk("busy_at_done", 32'(busy),      32'd0);
         end
      end
   end

   // Drive one command at the current falling edge; accepted at the next rising edge
   task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic uc, input logic cw, input bit track,
                        input logic [W-1:0] er, input logic [W-1:0] ehi,
                        input logic ec, input logic ef);
      exp_t e;
      op = o; a = va; b = vb; use_cin = uc; carry_wr = cw; start = 1'b1;
      @(posedge clk); #1;
      e.r = er; e.hi = ehi; e.c = ec; e.f = ef;
      e.cyc = cyc + ((o == 3'b100) ? W : 0);
      if (track) q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic chk_reset_state();
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_done",       32'(done),       32'd0);
      chk("rst_result",     32'(result),     32'd0);
      chk("rst_result_hi",  32'(result_hi),  32'd0);
      chk("rst_carry_out",  32'(carry_out),  32'd0);
      chk("rst_carry_flag", 32'(carry_flag), 32'd0);
   endtask

   initial begin
      int n;
      int busy_cycles;
      repeat (3) @(negedge clk);
      chk_reset_state();
      reset = 1'b0;

      // ADD with overflow, carry written; first start right after reset release
      issue(3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
      drain();
      issue(3'b000, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1);
      issue(3'b001, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 1'b1, 1'b1);
      issue(3'b011, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
      issue(3'b010, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
      issue(3'b101, 16'h0F0F, 16'h00FF, 1'b0, 1'b0, 1'b1, 16'h000F, 16'h0000, 1'b0, 1'b1);
      issue(3'b110, 16'hF000, 16'h000F, 1'b0, 1'b0, 1'b1, 16'hF00F, 16'h0000, 1'b0, 1'b1);
      // SUB with carry-in 1: 5-3+1=3, no borrow, flag cleared
      issue(3'b001, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b0);
      drain();

      // MUL FFFF*FFFF: 16 busy cycles, stray start at n+5 ignored, inputs scrambled mid-flight
      issue(3'b100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
      n = cyc;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         if (busy) busy_cycles++;
         if (cyc == n + 5) begin
            op = 3'b000; a = 16'h0001; b = 16'h0001; carry_wr = 1'b0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("mul_busy_cycles", 32'(busy_cycles), 32'd16);
      drain();
      issue(3'b100, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b1);
      drain();

      // Back-to-back: start held through the XOR done cycle
      op = 3'b111; a = 16'h00FF; b = 16'h0F0F; use_cin = 1'b0; carry_wr = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      q.push_back('{r: 16'h0FF0, hi: 16'h0000, c: 1'b0, f: 1'b1, cyc: cyc});
      @(negedge clk);
      op = 3'b000; a = 16'h0002; b = 16'h0003; use_cin = 1'b1;
      @(posedge clk); #1;
      q.push_back('{r: 16'h0006, hi: 16'h0000, c: 1'b0, f: 1'b1, cyc: cyc});
      @(negedge clk);
      start = 1'b0; use_cin = 1'b0;
      drain();

      // Reset at edge n+8 of a MUL aborts it: no done, outputs cleared, flag back to reset value
      issue(3'b100, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_state();
      @(negedge clk);
      reset = 1'b0;
      issue(3'b000, 16'h0007, 16'h0008, 1'b0, 1'b0, 1'b1, 16'h000F, 16'h0000, 1'b0, 1'b0);
      drain();
      repeat (25) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal range 4..32).
REQ-002 Parameter: CARRY_RESET, default 0, reset value of the internal carry flag.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request; the command is accepted when start=1 and busy=0.
REQ-006 op  input  3  opcode: 000 ADD, 001 SUB, 010 INC, 011 DEC, 100 MUL, 101 AND, 110 OR, 111 XOR.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 use_cin  input  1  add the stored carry flag as carry-in (ADD/SUB only).
REQ-010 carry_wr  input  1  on completion, write the carry result into the carry flag.
REQ-011 busy  output  1  high from the cycle after acceptance until done.
REQ-012 done  output  1  one-cycle pulse marking a valid result.
REQ-013 result  output  WIDTH  low WIDTH bits of the result; holds its value until the next done.
REQ-014 result_hi  output  WIDTH  upper WIDTH bits of the MUL product; 0 for all other ops.
REQ-015 carry_out  output  1  carry/borrow bit of the last result.
REQ-016 carry_flag  output  1  stored carry flag.

Function
REQ-017 Inputs op, a, b, use_cin and carry_wr are captured on acceptance; later changes have no effect on the operation in flight.
REQ-018 States: IDLE, MUL, DONE; reset enters IDLE.
REQ-019 IDLE: on acceptance go to DONE for ops other than MUL, and to MUL for MUL.
REQ-020 DONE: assert done for one cycle, update the outputs, return to IDLE; busy=0 in the same cycle as done.
REQ-021 Latency: start accepted at edge n -> done high in cycle n+1 for non-MUL ops, and in cycle n+WIDTH+1 for MUL.
REQ-022 start while busy=1 is ignored with no queueing; start in the done cycle is accepted (back-to-back operation).
REQ-023 Let cin = use_cin ? carry_flag : 0, with carry_flag sampled at acceptance.
REQ-024 ADD: s = {0,a} + {0,b} + cin, computed in WIDTH+1 bits; result = s[WIDTH-1:0]; carry_out = s[WIDTH].
REQ-025 SUB: s = ({0,a} - {0,b} + cin) mod 2^(WIDTH+1); carry_out = s[WIDTH], which is the borrow (1 when a+cin < b).
REQ-026 INC/DEC: s = {0,a} +/- 1, mod 2^(WIDTH+1); cin and b are ignored; carry_out = s[WIDTH].
REQ-027 AND/OR/XOR: bitwise on a and b; carry_out = 0.
REQ-028 MUL: unsigned shift-add multiply, one partial product per cycle, LSB of a first, WIDTH iterations.
REQ-029 MUL result: product P = a*b in 2*WIDTH bits; result = P[WIDTH-1:0]; result_hi = P[2*WIDTH-1:WIDTH]; carry_out = P[WIDTH].
REQ-030 carry_flag is written with carry_out in the done cycle only when the captured carry_wr=1; otherwise it holds.
REQ-031 result, result_hi and carry_out change only in the done cycle.

Reset
REQ-032 While reset=1: state=IDLE, busy=0, done=0, result=0, result_hi=0, carry_out=0, carry_flag=CARRY_RESET; start is ignored.
REQ-033 Reset during MUL or DONE aborts the operation: no done pulse is produced, and no carry_flag write occurs.
REQ-034 The first start is accepted in the cycle after reset deasserts.

Verification (WIDTH=16)
REQ-035 ADD a=FFFF, b=0001, carry_wr=1 -> done at n+1, result=0000, carry_out=1, carry_flag=1.
REQ-036 Then ADD a=0001, b=0001, use_cin=1 -> result=0003, carry_out=0.
REQ-037 SUB a=0003, b=0005, cin=0 -> result=FFFE, carry_out=1; DEC a=0000 -> result=FFFF, carry_out=1.
REQ-038 MUL a=FFFF, b=FFFF -> busy for 16 cycles, done at n+17, result=0001, result_hi=FFFE, carry_out=0; a start pulse at n+5 is ignored.
REQ-039 Back-to-back: start held through the done cycle of an XOR a=00FF, b=0F0F (result 0FF0) -> the next op is accepted in the done cycle and completes one cycle later.
REQ-040 Reset asserted at cycle n+8 of a MUL -> no done pulse, all outputs 0, carry_flag=CARRY_RESET; a new ADD after reset completes normally.
